// File: rtl/cc_update.sv
// cc_update: execute-stage OPq ALU and {zf,sf,of} condition-code register.
// Ports: clk/rst, E_icode/E_ifun, aluA/aluB, m_stat/W_stat -> e_valE, set_cc, cc, cc_updates.
module cc_update #(
    parameter int         WIDTH     = 64,
    parameter logic [3:0] ICODE_OPQ = 4'h6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [WIDTH-1:0] aluA,
    input  logic [WIDTH-1:0] aluB,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic [WIDTH-1:0] e_valE,
    output logic             set_cc,
    output logic [2:0]       cc,
    output logic [15:0]      cc_updates
);

    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_AND = 4'h2;
    localparam logic [3:0] FN_XOR = 4'h3;

    localparam logic [1:0] STAT_AOK = 2'd0;

    localparam logic [2:0]  CC_RST  = 3'b100;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic             is_opq;
    logic             fn_sub;
    logic             fn_and;
    logic             fn_xor;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             sa;
    logic             sb;
    logic             sr;
    logic             zf;
    logic             sf;
    logic             of;

    // Non-OPq instructions (address/PC arithmetic) and the
    // illegal ifun values 4..15 all fall through to add.
    assign is_opq = (E_icode == ICODE_OPQ);
    assign fn_sub = is_opq && (E_ifun == FN_SUB);
    assign fn_and = is_opq && (E_ifun == FN_AND);
    assign fn_xor = is_opq && (E_ifun == FN_XOR);

    assign sum  = aluB + aluA;
    assign diff = aluB - aluA;

    always_comb begin
        e_valE = sum;
        unique case (1'b1)
            fn_sub:  e_valE = diff;
            fn_and:  e_valE = aluB & aluA;
            fn_xor:  e_valE = aluB ^ aluA;
            default: e_valE = sum;
        endcase
    end

    assign sa = aluA[WIDTH-1];
    assign sb = aluB[WIDTH-1];
    assign sr = e_valE[WIDTH-1];

    assign zf = (e_valE == '0);
    assign sf = sr;

    // Overflow: add overflows when like-signed operands give a
    // result of the other sign; sub (B-A) overflows when the
    // operands differ in sign and the result departs from B.
    always_comb begin
        of = 1'b0;
        unique case (1'b1)
            fn_sub:          of = (sa != sb) && (sr != sb);
            fn_and, fn_xor:  of = 1'b0;
            default:         of = (sa == sb) && (sr != sa);
        endcase
    end

    // Any non-AOK status further down the pipe means an exception
    // is retiring ahead of this OPq, so its flags must not land.
    assign set_cc = is_opq
                 && (m_stat == STAT_AOK)
                 && (W_stat == STAT_AOK);

    always_ff @(posedge clk) begin
        if (rst) begin
            cc         <= CC_RST;
            cc_updates <= '0;
        end else if (set_cc) begin
            cc <= {zf, sf, of};
            if (cc_updates != CNT_MAX) begin
                cc_updates <= cc_updates + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cc_update.sv
// tb_cc_update: directed checks of cc_update ALU, flags, suppression,
// reset priority and write-counter saturation.
module tb_cc_update;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] aluA;
    logic [63:0] aluB;
    logic [1:0]  m_stat;
    logic [1:0]  W_stat;
    logic [63:0] e_valE;
    logic        set_cc;
    logic [2:0]  cc;
    logic [15:0] cc_updates;

    int checks = 0;
    int errors = 0;

    cc_update #(
        .WIDTH(64),
        .ICODE_OPQ(4'h6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .E_icode    (E_icode),
        .E_ifun     (E_ifun),
        .aluA       (aluA),
        .aluB       (aluB),
        .m_stat     (m_stat),
        .W_stat     (W_stat),
        .e_valE     (e_valE),
        .set_cc     (set_cc),
        .cc         (cc),
        .cc_updates (cc_updates)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] ms, input logic [1:0] ws);
        E_icode = ic;
        E_ifun  = fn;
        aluA    = a;
        aluB    = b;
        m_stat  = ms;
        W_stat  = ws;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(4'h6, 4'h0, 64'd3, 64'd4, 2'd0, 2'd0);
        tick();
        tick();
        rst = 1'b0;
        drive(4'h1, 4'h0, 64'd0, 64'd0, 2'd0, 2'd0);
        check("rst_cc", {61'd0, cc}, 64'h4);
        check("rst_cnt", {48'd0, cc_updates}, 64'd0);

        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF,
              64'h7FFF_FFFF_FFFF_FFFF, 2'd0, 2'd0);
        check("add_val", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        check("add_set", {63'd0, set_cc}, 64'd1);
        tick();
        check("add_cc", {61'd0, cc}, 64'h3);
        check("add_cnt", {48'd0, cc_updates}, 64'd1);

        drive(4'h6, 4'h1, 64'd5, 64'd5, 2'd0, 2'd0);
        check("sub0_val", e_valE, 64'd0);
        tick();
        check("sub0_cc", {61'd0, cc}, 64'h4);

        drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 2'd0, 2'd0);
        check("subov_val", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
        tick();
        check("subov_cc", {61'd0, cc}, 64'h1);
        check("subov_cnt", {48'd0, cc_updates}, 64'd3);

        drive(4'h6, 4'h2, 64'hF0, 64'h0F, 2'd0, 2'd0);
        check("and_val", e_valE, 64'd0);
        tick();
        check("and_cc", {61'd0, cc}, 64'h4);

        drive(4'h6, 4'h3, 64'hF0, 64'h0F, 2'd0, 2'd0);
        check("xor_val", e_valE, 64'hFF);
        tick();
        check("xor_cc", {61'd0, cc}, 64'h0);
        check("xor_cnt", {48'd0, cc_updates}, 64'd5);

        drive(4'h6, 4'h2, 64'hF0, 64'h0F, 2'd2, 2'd0);
        check("madr_val", e_valE, 64'd0);
        check("madr_set", {63'd0, set_cc}, 64'd0);
        tick();
        check("madr_cc", {61'd0, cc}, 64'h0);
        check("madr_cnt", {48'd0, cc_updates}, 64'd5);

        drive(4'h6, 4'h2, 64'hF0, 64'h0F, 2'd0, 2'd1);
        check("whlt_set", {63'd0, set_cc}, 64'd0);
        tick();
        check("whlt_cc", {61'd0, cc}, 64'h0);
        check("whlt_cnt", {48'd0, cc_updates}, 64'd5);

        drive(4'h6, 4'h1, 64'd5, 64'd5, 2'd3, 2'd0);
        check("mins_set", {63'd0, set_cc}, 64'd0);
        tick();
        check("mins_cc", {61'd0, cc}, 64'h0);

        drive(4'h5, 4'h0, 64'd8, 64'd16, 2'd0, 2'd0);
        check("mr_val", e_valE, 64'd24);
        check("mr_set", {63'd0, set_cc}, 64'd0);
        tick();
        check("mr_cc", {61'd0, cc}, 64'h0);

        drive(4'h5, 4'h1, 64'd8, 64'd16, 2'd0, 2'd0);
        check("nonopq_sub", e_valE, 64'd24);

        drive(4'h6, 4'h4, 64'd1, 64'd2, 2'd0, 2'd0);
        check("badfn_val", e_valE, 64'd3);
        tick();
        check("badfn_cc", {61'd0, cc}, 64'h0);
        check("badfn_cnt", {48'd0, cc_updates}, 64'd6);

        drive(4'h6, 4'h0, 64'h8000_0000_0000_0000,
              64'h8000_0000_0000_0000, 2'd0, 2'd0);
        check("addneg_val", e_valE, 64'd0);
        tick();
        check("addneg_cc", {61'd0, cc}, 64'h5);

        drive(4'h6, 4'h3, 64'd0, 64'hFF00_0000_0000_0000, 2'd0, 2'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(4'h1, 4'h0, 64'd0, 64'd0, 2'd0, 2'd0);
        check("midrst_cc", {61'd0, cc}, 64'h4);
        check("midrst_cnt", {48'd0, cc_updates}, 64'd0);

        drive(4'h6, 4'h0, 64'd0, 64'd0, 2'd0, 2'd0);
        repeat (65535) @(posedge clk);
        #1;
        check("sat_reach", {48'd0, cc_updates}, 64'hFFFF);
        tick();
        check("sat_hold", {48'd0, cc_updates}, 64'hFFFF);
        check("sat_cc", {61'd0, cc}, 64'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_update.md
# cc_update

Execute-stage ALU and condition-code register for the pipelined Y86-64 core. It performs the OPq arithmetic (`addq`, `subq`, `andq`, `xorq`) and derives ZF, SF and OF from the result. It holds those flags in a 3-bit register that updates only when pipeline state allows. Its registered `cc` output is the packed `{zf,sf,of}` vector that the branch/cmov condition evaluator consumes.

## Interface
Parameters:
- WIDTH, 64, data path width in bits.
- ICODE_OPQ, 4'h6, icode of the OPq instruction class.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- E_icode  in  4  icode of the instruction in the execute stage.
- E_ifun  in  4  ifun in the execute stage: 0 add, 1 sub, 2 and, 3 xor.
- aluA  in  WIDTH  ALU operand A (valA, valC or constant, already selected).
- aluB  in  WIDTH  ALU operand B.
- m_stat  in  2  status of the instruction in the memory stage: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- W_stat  in  2  status of the instruction in the write-back stage (same encoding).
- e_valE  out  WIDTH  combinational ALU result.
- set_cc  out  1  combinational update enable (exported for debug/trace).
- cc  out  3  registered flags `{zf,sf,of}`.
- cc_updates  out  16  count of committed CC writes, saturating.

## Operation
- ALU function (combinational, wraps modulo 2^WIDTH):
  - When `E_icode==ICODE_OPQ`, `E_ifun` selects the operation: 0 gives `aluB+aluA`; 1 gives `aluB-aluA`; 2 gives `aluB&aluA`; 3 gives `aluB^aluA`.
  - Otherwise the ALU computes `aluB+aluA`, which address and PC computations use.
  - `E_ifun` values 4–15 with OPq select add; the decode stage has already flagged these as INS.
- Flag derivation from `e_valE`; `a`, `b` and `r` below are the sign bits of aluA, aluB and the result:
  - zf = (e_valE == 0).
  - sf = e_valE[WIDTH-1].
  - of for add = (a==b) && (r!=a).
  - of for sub = (a!=b) && (r!=b).
  - of for and and xor = 0.
- set_cc = `(E_icode==ICODE_OPQ) && !(m_stat inside {HLT,ADR,INS}) && !(W_stat inside {HLT,ADR,INS})`.
  - A bubble in E arrives as a nop icode, so it never sets CC; no separate bubble input exists.
- CC register:
  - On `rst`, cc <= 3'b100 (ZF=1, SF=0, OF=0).
  - Otherwise, when set_cc is high, cc <= {zf,sf,of}.
  - Otherwise cc holds.
- Write counter:
  - On `rst`, cc_updates <= 0.
  - It increments on every cycle where set_cc is high and saturates at 16'hFFFF.

## Timing
- e_valE and set_cc have zero-cycle latency and depend only on the current inputs.
- cc has a one-cycle latency: flags produced by an OPq in E during cycle N are visible on cc from cycle N+1.
  - A conditional jump or cmov in E during cycle N+1 therefore sees the flags of the immediately preceding OPq. No forwarding is needed.
- A jXX or cmov in E during cycle N sees the cc value from before cycle N's edge. This holds even if an OPq is also computing in the same cycle, which is impossible in a single-issue pipeline.
- Exception suppression:
  - If m_stat or W_stat is non-AOK in cycle N, an OPq in E during cycle N does not write cc and does not count.
  - The OPq still produces e_valE.
- Reset mid-operation: when rst is high, reset takes priority over a simultaneous set_cc. cc equals 3'b100 and cc_updates equals 0 in the following cycle.
- Back-to-back OPq instructions update cc every cycle; the last one wins.

## Test plan
- Reset: hold rst for 2 cycles with an OPq present → cc==3'b100 and cc_updates==0 after release.
- Add overflow: E_icode=6, E_ifun=0, aluA=aluB=64'h7FFF_FFFF_FFFF_FFFF → e_valE==64'hFFFF_FFFF_FFFF_FFFE and set_cc==1; next cycle cc==3'b011 and cc_updates==1.
- Sub to zero, then sub overflow:
  - First: aluA=aluB=5, ifun 1 → cc==3'b100.
  - Next: aluB=64'h8000_0000_0000_0000, aluA=1 → e_valE==64'h7FFF_FFFF_FFFF_FFFF and cc==3'b001.
- And/xor: aluA=64'hF0, aluB=64'h0F, ifun 2 → e_valE==0 and cc==3'b100. Then ifun 3 → e_valE==64'hFF and cc==3'b000.
- Exception suppression: with cc==3'b000, an OPq producing zero while m_stat==2 (ADR) → set_cc==0, cc stays 3'b000 and the count is unchanged. Repeat with W_stat==1 (HLT) and expect the same result.
- Non-OPq and saturation:
  - E_icode=4'h5 (mrmovq), aluA=8, aluB=16 → e_valE==24 and cc unchanged.
  - Force cc_updates to 16'hFFFF, then issue an OPq → cc_updates stays 16'hFFFF.
